ball_rx_handoff: RTL and testbench
==================================

Name: ball_rx_handoff

Overview:
- Sits directly downstream of the I2C interface's slave register outputs and consumes the ball-handoff frame sent by the opponent board.
- On each completed slave write it does the following:
  - captures the six received bytes;
  - validates them;
  - reconstructs ball state;
  - presents the state to local game logic with a valid/accept handshake.
- Also flags a win notification, frame errors, overruns, and a link timeout while the local side waits for the remote player.

Parameters:
- SETTLE_CYC, 4: cycles between the is_slave_done rising edge and byte sampling (range 1..15).
- Y_MAX, 479: largest legal ball_y.
- TIMEOUT_CYC, 100_000_000: wait cycles before link_timeout asserts (1 s at 100 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- is_slave_done  in  1  slave write complete (level or pulse; rising edge used).
- i_y_pos0  in  8  ball_y[7:0].
- i_y_pos1  in  8  ball_y[9:8] in bits [1:0]; bits [7:2] must be 0.
- i_y_vel  in  8  signed vertical velocity (two's complement).
- i_gravity  in  8  gravity counter in bits [1:0]; bits [7:2] must be 0.
- i_is_collusion  in  8  0x00 or 0x01.
- i_is_win_flag  in  8  0x00 or 0x01.
- wait_remote  in  1  local side is waiting for the opponent's frame.
- ball_accept  in  1  game logic takes the pending ball.
- ball_valid  out  1  a received ball is pending.
- rx_ball_y  out  10  reconstructed y.
- rx_ball_vy  out  8  velocity.
- rx_gravity  out  2  gravity counter.
- rx_collision  out  1  collision flag.
- game_win  out  1  one-cycle pulse when the opponent reports a loss.
- frame_err  out  1  one-cycle pulse on an invalid frame.
- overrun_err  out  1  one-cycle pulse when a frame arrives while a ball is pending.
- link_timeout  out  1  level; no frame received within TIMEOUT_CYC.
- err_cnt  out  8  saturating count of frame_err plus overrun_err events.

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0.
  - Edge detector register 0, so a high is_slave_done at reset release counts as an edge one cycle later.
  - Settle and watchdog counters 0.
  - Reset mid-frame discards everything.
- Edge detect: done_rise = is_slave_done & ~done_d, where done_d is registered every cycle.
- IDLE:
  - On done_rise, go to SETTLE and load the settle counter with SETTLE_CYC-1.
- SETTLE:
  - Decrement each cycle.
  - At 0, register all six bytes into capture registers and go to CHECK.
  - A done_rise inside SETTLE restarts the counter (the latest write wins).
- CHECK (one cycle). The frame is valid iff all of the following hold:
  - i_y_pos1[7:2]==0;
  - i_gravity[7:2]==0;
  - collision byte and win byte are each 0x00 or 0x01;
  - {pos1[1:0],pos0} <= Y_MAX.
- CHECK outcomes:
  - Invalid frame: pulse frame_err, increment err_cnt, go to IDLE. Outputs are unchanged.
  - Valid with win=1: pulse game_win, go to IDLE. No ball is presented.
  - Valid with win=0: load the rx_* outputs, set ball_valid, go to PENDING.
  - Total latency from done_rise to ball_valid: SETTLE_CYC+2 cycles.
- PENDING:
  - rx_* outputs are held stable while ball_valid=1.
  - If ball_accept=1 in a cycle with ball_valid=1, the transfer happens: ball_valid clears next cycle and the state goes to IDLE.
  - The rx_* outputs keep their last values after accept.
- Overrun in PENDING:
  - A done_rise with no same-cycle accept pulses overrun_err, increments err_cnt, and drops the new frame (the old ball is kept).
  - If done_rise and accept occur in the same cycle, the transfer completes and the new frame is processed from SETTLE; no error.
- ball_accept while ball_valid=0 is ignored.
- err_cnt saturates at 255. If frame_err and overrun_err would both fire in one cycle, the increment is 1; the FSM prevents this anyway.
- Watchdog:
  - Counts while wait_remote=1 and state is IDLE.
  - Cleared when wait_remote=0 or on any done_rise.
  - When the count reaches TIMEOUT_CYC-1, link_timeout asserts on the next cycle.
  - link_timeout stays high until a valid frame (ball or win) passes CHECK, or wait_remote falls.
  - The counter saturates and does not wrap.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- SETTLE_CYC=4: pos0=0x2C, pos1=0x01, vel=0xFD, grav=0x02, coll=0x01, win=0, done 0→1 at cycle 10 → ball_valid=1 at cycle 16, rx_ball_y=300, rx_ball_vy=0xFD, rx_gravity=2, rx_collision=1; accept at cycle 20 → ball_valid=0 at 21.
- Invalid frames, each sent separately:
  - pos1=0x01, pos0=0xE0 (y=480) → frame_err pulse, err_cnt=1, ball_valid stays 0.
  - grav=0x04 → err_cnt=2.
  - coll=0x02 → err_cnt=3.
- win=0x01 with valid fields → single-cycle game_win, ball_valid stays 0, no error.
- Ball pending with accept held low, second done_rise → overrun_err pulse, rx_ball_y keeps first value; then done_rise in the same cycle as accept → no error, second ball valid SETTLE_CYC+2 cycles later.
- TIMEOUT_CYC=50, wait_remote=1, no frames → link_timeout=1 at cycle 50 after wait_remote rose; valid frame → link_timeout=0 the cycle after CHECK; 300 error events → err_cnt=255.
- Reset asserted during SETTLE and during PENDING → next cycle all outputs 0, state IDLE; a later frame is processed normally.

Source files
------------

// File: rtl/ball_rx_handoff.sv
// Receives the opponent's six-byte ball-handoff frame from the I2C slave registers,
// validates it and hands the reconstructed ball to local game logic via valid/accept.
module ball_rx_handoff #(
    parameter int SETTLE_CYC  = 4,
    parameter int Y_MAX       = 479,
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       is_slave_done,
    input  logic [7:0] i_y_pos0,
    input  logic [7:0] i_y_pos1,
    input  logic [7:0] i_y_vel,
    input  logic [7:0] i_gravity,
    input  logic [7:0] i_is_collusion,
    input  logic [7:0] i_is_win_flag,
    input  logic       wait_remote,
    input  logic       ball_accept,
    output logic       ball_valid,
    output logic [9:0] rx_ball_y,
    output logic [7:0] rx_ball_vy,
    output logic [1:0] rx_gravity,
    output logic       rx_collision,
    output logic       game_win,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       link_timeout,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, PENDING} state_t;

    localparam int              WD_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX      = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYC - 1);
    localparam logic [9:0]      Y_LIMIT     = 10'(Y_MAX);

    state_t          state;
    logic            done_d;
    logic [3:0]      settle_cnt;
    logic [7:0]      cap_pos0;
    logic [7:0]      cap_pos1;
    logic [7:0]      cap_vel;
    logic [7:0]      cap_grav;
    logic [7:0]      cap_coll;
    logic [7:0]      cap_win;
    logic [WD_W-1:0] wd_cnt;

    logic       done_rise;
    logic [9:0] cap_y;
    logic       frame_ok;
    logic       err_event;

    assign done_rise = is_slave_done & ~done_d;
    assign cap_y     = {cap_pos1[1:0], cap_pos0};
    assign frame_ok  = (cap_pos1[7:2] == 6'd0) && (cap_grav[7:2] == 6'd0) &&
                       (cap_coll[7:1] == 7'd0) && (cap_win[7:1] == 7'd0) &&
                       (cap_y <= Y_LIMIT);
    // At most one of these can be true per cycle since they live in different states.
    assign err_event = ((state == CHECK) && !frame_ok) ||
                       ((state == PENDING) && done_rise && !ball_accept);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            done_d       <= 1'b0;
            settle_cnt   <= 4'd0;
            cap_pos0     <= 8'd0;
            cap_pos1     <= 8'd0;
            cap_vel      <= 8'd0;
            cap_grav     <= 8'd0;
            cap_coll     <= 8'd0;
            cap_win      <= 8'd0;
            ball_valid   <= 1'b0;
            rx_ball_y    <= 10'd0;
            rx_ball_vy   <= 8'd0;
            rx_gravity   <= 2'd0;
            rx_collision <= 1'b0;
            game_win     <= 1'b0;
            frame_err    <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            done_d      <= is_slave_done;
            game_win    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (done_rise) begin
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    // A fresh write restarts the settle window so the newest bytes are taken.
                    if (done_rise) begin
                        settle_cnt <= SETTLE_LOAD;
                    end else if (settle_cnt == 4'd0) begin
                        cap_pos0 <= i_y_pos0;
                        cap_pos1 <= i_y_pos1;
                        cap_vel  <= i_y_vel;
                        cap_grav <= i_gravity;
                        cap_coll <= i_is_collusion;
                        cap_win  <= i_is_win_flag;
                        state    <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CHECK: begin
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (cap_win[0]) begin
                        game_win <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        rx_ball_y    <= cap_y;
                        rx_ball_vy   <= cap_vel;
                        rx_gravity   <= cap_grav[1:0];
                        rx_collision <= cap_coll[0];
                        ball_valid   <= 1'b1;
                        state        <= PENDING;
                    end
                end
                PENDING: begin
                    if (ball_accept) begin
                        ball_valid <= 1'b0;
                        if (done_rise) begin
                            settle_cnt <= SETTLE_LOAD;
                            state      <= SETTLE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (done_rise) begin
                        overrun_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= 8'd0;
        end else if (err_event && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    // Watchdog only advances while idle and waiting; it parks at its limit instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt       <= '0;
            link_timeout <= 1'b0;
        end else begin
            if (!wait_remote || done_rise) begin
                wd_cnt <= '0;
            end else if ((state == IDLE) && (wd_cnt != WD_MAX)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (!wait_remote || ((state == CHECK) && frame_ok)) begin
                link_timeout <= 1'b0;
            end else if ((state == IDLE) && (wd_cnt == WD_MAX) && !done_rise) begin
                link_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ball_rx_handoff.sv
// Self-checking bench for ball_rx_handoff: directed scenarios plus randomized frames
// judged by a simple arithmetic model of frame legality and ball reconstruction.
module tb_ball_rx_handoff;

    localparam int SETTLE = 4;
    localparam int YMAX   = 479;
    localparam int TMO    = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       is_slave_done;
    logic [7:0] i_y_pos0, i_y_pos1, i_y_vel, i_gravity, i_is_collusion, i_is_win_flag;
    logic       wait_remote;
    logic       ball_accept;
    logic       ball_valid;
    logic [9:0] rx_ball_y;
    logic [7:0] rx_ball_vy;
    logic [1:0] rx_gravity;
    logic       rx_collision;
    logic       game_win, frame_err, overrun_err, link_timeout;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_err  = 0;
    int n_win    = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;

    ball_rx_handoff #(.SETTLE_CYC(SETTLE), .Y_MAX(YMAX), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .is_slave_done(is_slave_done),
        .i_y_pos0(i_y_pos0), .i_y_pos1(i_y_pos1), .i_y_vel(i_y_vel),
        .i_gravity(i_gravity), .i_is_collusion(i_is_collusion), .i_is_win_flag(i_is_win_flag),
        .wait_remote(wait_remote), .ball_accept(ball_accept),
        .ball_valid(ball_valid), .rx_ball_y(rx_ball_y), .rx_ball_vy(rx_ball_vy),
        .rx_gravity(rx_gravity), .rx_collision(rx_collision), .game_win(game_win),
        .frame_err(frame_err), .overrun_err(overrun_err), .link_timeout(link_timeout),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Pulse tallies, sampled mid-cycle so every one-cycle pulse is seen exactly once.
    always @(negedge clk) begin
        if (game_win)    n_win++;
        if (frame_err)   n_ferr++;
        if (overrun_err) n_ovr++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one slave write; returns just after the edge that sees the rise.
    task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] v,
                              input logic [7:0] g, input logic [7:0] c, input logic [7:0] w);
        i_y_pos0 = p0; i_y_pos1 = p1; i_y_vel = v;
        i_gravity = g; i_is_collusion = c; i_is_win_flag = w;
        is_slave_done = 1'b1;
        tick(1);
        is_slave_done = 1'b0;
    endtask

    function automatic bit model_valid(input int p0, input int p1, input int g,
                                       input int c, input int w);
        return (p1 < 4) && (g < 4) && (c < 2) && (w < 2) && ((p1 * 256 + p0) <= YMAX);
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        checks++;
        if ({ball_valid, rx_ball_y, rx_ball_vy, rx_gravity, rx_collision, game_win,
             frame_err, overrun_err, link_timeout, err_cnt} !== 35'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got nonzero outputs (y=%0d err=%0d v=%0b) expected all 0",
                     rx_ball_y, err_cnt, ball_valid);
        end
        reset = 1'b0;
        tick(3);
        checks++;
        if ({ball_valid, link_timeout, err_cnt} !== 10'd0) begin
            failures++;
            $display("[TB] FAIL reset_release: got valid=%0b timeout=%0b err=%0d expected 0/0/0",
                     ball_valid, link_timeout, err_cnt);
        end
    endtask

    task automatic test_basic;
        send_frame(8'h2C, 8'h01, 8'hFD, 8'h02, 8'h01, 8'h00);
        tick(SETTLE);
        checks++;
        if (ball_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_early: got ball_valid=%0b expected 0", ball_valid);
        end
        tick(1);
        checks++;
        if (ball_valid !== 1'b1 || rx_ball_y !== 10'd300 || rx_ball_vy !== 8'hFD ||
            rx_gravity !== 2'd2 || rx_collision !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_ball: got v=%0b y=%0d vy=%h g=%0d c=%0b expected 1/300/fd/2/1",
                     ball_valid, rx_ball_y, rx_ball_vy, rx_gravity, rx_collision);
        end
        tick(3);
        checks++;
        if (ball_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_hold: got ball_valid=%0b expected 1", ball_valid);
        end
        ball_accept = 1'b1;
        tick(1);
        ball_accept = 1'b0;
        checks++;
        if (ball_valid !== 1'b0 || rx_ball_y !== 10'd300 || err_cnt !== 8'(exp_err)) begin
            failures++;
            $display("[TB] FAIL basic_accept: got v=%0b y=%0d err=%0d expected 0/300/%0d",
                     ball_valid, rx_ball_y, err_cnt, exp_err);
        end
    endtask

    task automatic test_invalid;
        logic [7:0] tbl [3][6];
        tbl[0] = '{8'hE0, 8'h01, 8'h05, 8'h00, 8'h00, 8'h00};
        tbl[1] = '{8'h10, 8'h00, 8'h05, 8'h04, 8'h00, 8'h00};
        tbl[2] = '{8'h10, 8'h00, 8'h05, 8'h00, 8'h02, 8'h00};
        for (int k = 0; k < 3; k++) begin
            send_frame(tbl[k][0], tbl[k][1], tbl[k][2], tbl[k][3], tbl[k][4], tbl[k][5]);
            tick(SETTLE + 1);
            exp_err = sat_add(exp_err, 1);
            checks++;
            if (frame_err !== 1'b1 || err_cnt !== 8'(exp_err) || ball_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL invalid_%0d: got ferr=%0b err=%0d v=%0b expected 1/%0d/0",
                         k, frame_err, err_cnt, ball_valid, exp_err);
            end
            tick(1);
            checks++;
            if (frame_err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL invalid_pulse_%0d: got frame_err=%0b expected 0", k, frame_err);
            end
        end
    endtask

    task automatic test_win;
        send_frame(8'h20, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01);
        tick(SETTLE + 1);
        checks++;
        if (game_win !== 1'b1 || ball_valid !== 1'b0 || frame_err !== 1'b0 ||
            err_cnt !== 8'(exp_err)) begin
            failures++;
            $display("[TB] FAIL win: got win=%0b v=%0b ferr=%0b err=%0d expected 1/0/0/%0d",
                     game_win, ball_valid, frame_err, err_cnt, exp_err);
        end
        tick(1);
        checks++;
        if (game_win !== 1'b0) begin
            failures++;
            $display("[TB] FAIL win_pulse: got game_win=%0b expected 0", game_win);
        end
    endtask

    task automatic test_overrun;
        send_frame(8'd100, 8'h00, 8'h11, 8'h01, 8'h00, 8'h00);
        tick(SETTLE + 1);
        send_frame(8'd200, 8'h00, 8'h22, 8'h02, 8'h01, 8'h00);
        exp_err = sat_add(exp_err, 1);
        checks++;
        if (overrun_err !== 1'b1 || rx_ball_y !== 10'd100 || err_cnt !== 8'(exp_err)) begin
            failures++;
            $display("[TB] FAIL overrun: got ovr=%0b y=%0d err=%0d expected 1/100/%0d",
                     overrun_err, rx_ball_y, err_cnt, exp_err);
        end
        tick(SETTLE + 4);
        checks++;
        if (ball_valid !== 1'b1 || rx_ball_y !== 10'd100 || rx_ball_vy !== 8'h11) begin
            failures++;
            $display("[TB] FAIL overrun_keep: got v=%0b y=%0d vy=%h expected 1/100/11",
                     ball_valid, rx_ball_y, rx_ball_vy);
        end
    endtask

    task automatic test_back_to_back;
        i_y_pos0 = 8'd200; i_y_pos1 = 8'h00; i_y_vel = 8'h22;
        i_gravity = 8'h02; i_is_collusion = 8'h01; i_is_win_flag = 8'h00;
        is_slave_done = 1'b1;
        ball_accept = 1'b1;
        tick(1);
        is_slave_done = 1'b0;
        ball_accept = 1'b0;
        checks++;
        if (ball_valid !== 1'b0 || overrun_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_accept: got v=%0b ovr=%0b expected 0/0", ball_valid, overrun_err);
        end
        tick(SETTLE);
        checks++;
        if (ball_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_early: got ball_valid=%0b expected 0", ball_valid);
        end
        tick(1);
        checks++;
        if (ball_valid !== 1'b1 || rx_ball_y !== 10'd200 || rx_gravity !== 2'd2 ||
            err_cnt !== 8'(exp_err)) begin
            failures++;
            $display("[TB] FAIL b2b_ball: got v=%0b y=%0d g=%0d err=%0d expected 1/200/2/%0d",
                     ball_valid, rx_ball_y, rx_gravity, err_cnt, exp_err);
        end
        ball_accept = 1'b1;
        tick(1);
        ball_accept = 1'b0;
    endtask

    task automatic test_random;
        int p0, p1, v, g, c, w, win0, ferr0, dly;
        bit ok;
        int last_y = 200;
        for (int it = 0; it < 40; it++) begin
            p0 = int'($urandom_range(0, 255));
            p1 = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            v  = int'($urandom_range(0, 255));
            g  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            c  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 255));
            w  = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(0, 2));
            ok = model_valid(p0, p1, g, c, w);
            win0 = n_win;
            ferr0 = n_ferr;
            send_frame(8'(p0), 8'(p1), 8'(v), 8'(g), 8'(c), 8'(w));
            tick(SETTLE + 1);
            if (!ok) exp_err = sat_add(exp_err, 1);
            checks++;
            if (ok && w == 0) begin
                last_y = p1 * 256 + p0;
                if (ball_valid !== 1'b1 || rx_ball_y !== 10'(last_y) || rx_ball_vy !== 8'(v) ||
                    rx_gravity !== 2'(g) || rx_collision !== 1'(c)) begin
                    failures++;
                    $display("[TB] FAIL rand_ball_%0d: got v=%0b y=%0d vy=%h g=%0d c=%0b expected 1/%0d/%h/%0d/%0d",
                             it, ball_valid, rx_ball_y, rx_ball_vy, rx_gravity, rx_collision,
                             last_y, 8'(v), g, c);
                end
            end else if (ball_valid !== 1'b0 || rx_ball_y !== 10'(last_y)) begin
                failures++;
                $display("[TB] FAIL rand_noball_%0d: got v=%0b y=%0d expected 0/%0d",
                         it, ball_valid, rx_ball_y, last_y);
            end
            tick(2);
            checks++;
            if ((n_ferr - ferr0) != int'(!ok) || (n_win - win0) != int'(ok && w == 1) ||
                err_cnt !== 8'(exp_err)) begin
                failures++;
                $display("[TB] FAIL rand_flags_%0d: got ferr=%0d win=%0d err=%0d expected %0d/%0d/%0d",
                         it, n_ferr - ferr0, n_win - win0, err_cnt, int'(!ok), int'(ok && w == 1), exp_err);
            end
            if (ok && w == 0) begin
                dly = int'($urandom_range(0, 3));
                tick(dly);
                ball_accept = 1'b1;
                tick(1);
                ball_accept = 1'b0;
                checks++;
                if (ball_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL rand_accept_%0d: got ball_valid=%0b expected 0", it, ball_valid);
                end
            end
        end
    endtask

    task automatic test_timeout;
        wait_remote = 1'b1;
        tick(TMO - 1);
        checks++;
        if (link_timeout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_early: got link_timeout=%0b expected 0", link_timeout);
        end
        tick(1);
        checks++;
        if (link_timeout !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_assert: got link_timeout=%0b expected 1", link_timeout);
        end
        tick(10);
        send_frame(8'd50, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00);
        tick(SETTLE);
        checks++;
        if (link_timeout !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_hold: got link_timeout=%0b expected 1", link_timeout);
        end
        tick(1);
        checks++;
        if (link_timeout !== 1'b0 || ball_valid !== 1'b1 || rx_ball_y !== 10'd50) begin
            failures++;
            $display("[TB] FAIL timeout_clear: got lt=%0b v=%0b y=%0d expected 0/1/50",
                     link_timeout, ball_valid, rx_ball_y);
        end
        ball_accept = 1'b1;
        tick(1);
        ball_accept = 1'b0;
        tick(TMO + 5);
        checks++;
        if (link_timeout !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_rearm: got link_timeout=%0b expected 1", link_timeout);
        end
        wait_remote = 1'b0;
        tick(1);
        checks++;
        if (link_timeout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_drop: got link_timeout=%0b expected 0", link_timeout);
        end
    endtask

    task automatic test_saturate;
        int ferr0 = n_ferr;
        for (int k = 0; k < 300; k++) begin
            send_frame(8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
            tick(SETTLE + 2);
        end
        exp_err = sat_add(exp_err, 300);
        checks++;
        if (err_cnt !== 8'(exp_err) || (n_ferr - ferr0) != 300) begin
            failures++;
            $display("[TB] FAIL saturate: got err=%0d events=%0d expected %0d/300",
                     err_cnt, n_ferr - ferr0, exp_err);
        end
    endtask

    task automatic test_reset_mid;
        send_frame(8'd10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00);
        tick(1);
        reset = 1'b1;
        tick(1);
        checks++;
        if ({ball_valid, rx_ball_y, rx_ball_vy, rx_gravity, rx_collision, game_win,
             frame_err, overrun_err, link_timeout, err_cnt} !== 35'd0) begin
            failures++;
            $display("[TB] FAIL reset_settle: got y=%0d err=%0d v=%0b expected all 0",
                     rx_ball_y, err_cnt, ball_valid);
        end
        reset = 1'b0;
        exp_err = 0;
        tick(SETTLE + 6);
        checks++;
        if (ball_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_discard: got ball_valid=%0b expected 0", ball_valid);
        end
        send_frame(8'd123, 8'h00, 8'h44, 8'h03, 8'h01, 8'h00);
        tick(SETTLE + 1);
        reset = 1'b1;
        tick(1);
        checks++;
        if ({ball_valid, rx_ball_y, rx_ball_vy, rx_gravity, rx_collision, game_win,
             frame_err, overrun_err, link_timeout, err_cnt} !== 35'd0) begin
            failures++;
            $display("[TB] FAIL reset_pending: got y=%0d vy=%h v=%0b expected all 0",
                     rx_ball_y, rx_ball_vy, ball_valid);
        end
        reset = 1'b0;
        tick(2);
        send_frame(8'd77, 8'h01, 8'h55, 8'h01, 8'h00, 8'h00);
        tick(SETTLE + 1);
        checks++;
        if (ball_valid !== 1'b1 || rx_ball_y !== 10'd333 || rx_ball_vy !== 8'h55 ||
            err_cnt !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_recover: got v=%0b y=%0d vy=%h err=%0d expected 1/333/55/0",
                     ball_valid, rx_ball_y, rx_ball_vy, err_cnt);
        end
        ball_accept = 1'b1;
        tick(1);
        ball_accept = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        is_slave_done = 1'b0;
        wait_remote = 1'b0;
        ball_accept = 1'b0;
        i_y_pos0 = 8'h00; i_y_pos1 = 8'h00; i_y_vel = 8'h00;
        i_gravity = 8'h00; i_is_collusion = 8'h00; i_is_win_flag = 8'h00;
        test_reset;
        test_basic;
        test_invalid;
        test_win;
        test_overrun;
        test_back_to_back;
        test_random;
        test_timeout;
        test_saturate;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
